// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline stage after execute. It performs at most one
// data-memory load or store per operation over a req/ack handshake, then
// emits a one-cycle writeback packet. It also owns the {V,C,N,Z} status
// register and stalls execute (in_ready low) while an operation is in flight.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // execute-side interface
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_fout,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_write,
  input  logic [3:0]        in_flags,
  input  logic              in_set_flags,
  // data-memory interface
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  // writeback interface
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  // status
  output logic [3:0]        status_flags,
  output logic              mem_error
);

  // The wait counter is 8 bits wide; TIMEOUT is limited to 1..255.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WB     = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  // request registers, held stable for the whole ACCESS phase
  logic              req_we_reg;
  logic [DATA_W-1:0] req_addr_reg;
  logic [DATA_W-1:0] req_wdata_reg;
  logic [4:0]        pend_rd_reg;

  // writeback registers, only updated on the edge that enters WB
  logic              wb_valid_reg;
  logic              wb_we_reg;
  logic [4:0]        wb_rd_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              mem_error_reg;
  logic [3:0]        flags_reg;

  // decoded controls
  logic              accept;
  logic              is_mem;
  logic              bad_op;
  logic              start_access;
  logic              enter_wb;
  logic              wb_err_next;
  logic              wb_we_next;
  logic [4:0]        wb_rd_next;
  logic [DATA_W-1:0] wb_data_next;

  assign accept = in_valid && (state_reg == IDLE);
  assign is_mem = in_mem_read || in_mem_write;
  // read+write together, or a non-word-aligned address, is never sent to memory
  assign bad_op = (in_mem_read && in_mem_write) || (in_fout[1:0] != 2'b00);

  // Next-state logic and the values to load into the writeback registers.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    start_access = 1'b0;
    enter_wb     = 1'b0;
    wb_err_next  = 1'b0;
    wb_we_next   = 1'b0;
    wb_rd_next   = pend_rd_reg;
    wb_data_next = req_addr_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (is_mem && !bad_op) begin
            state_next   = ACCESS;
            start_access = 1'b1;
            cnt_next     = 8'd0;
          end else begin
            // ALU result, or a rejected memory op that goes straight to WB
            state_next   = WB;
            enter_wb     = 1'b1;
            wb_err_next  = is_mem;
            wb_we_next   = !is_mem && in_reg_write && (in_rd != 5'd0);
            wb_rd_next   = in_rd;
            wb_data_next = in_fout;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // an ack in the final allowed cycle still wins over the timeout
          state_next   = WB;
          enter_wb     = 1'b1;
          cnt_next     = 8'd0;
          wb_we_next   = !req_we_reg && (pend_rd_reg != 5'd0);
          wb_data_next = req_we_reg ? req_addr_reg : dmem_rdata;
        end else if (cnt_reg + 8'd1 == TIMEOUT_CNT) begin
          state_next   = WB;
          enter_wb     = 1'b1;
          cnt_next     = 8'd0;
          wb_err_next  = 1'b1;
          wb_we_next   = 1'b0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      WB: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and ack-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the memory request when a legal memory op is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      pend_rd_reg   <= 5'd0;
    end else if (start_access) begin
      req_we_reg    <= in_mem_write;
      req_addr_reg  <= in_fout;
      req_wdata_reg <= in_store_data;
      pend_rd_reg   <= in_rd;
    end
  end

  // Writeback packet: pulse valid/error for one cycle, hold the payload otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_reg  <= 1'b0;
      mem_error_reg <= 1'b0;
      wb_we_reg     <= 1'b0;
      wb_rd_reg     <= 5'd0;
      wb_data_reg   <= '0;
    end else begin
      wb_valid_reg  <= enter_wb;
      mem_error_reg <= enter_wb && wb_err_next;
      if (enter_wb) begin
        wb_we_reg   <= wb_we_next;
        wb_rd_reg   <= wb_rd_next;
        wb_data_reg <= wb_data_next;
      end
    end
  end

  // Status register follows execute's flags on accept, regardless of the memory outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= 4'd0;
    end else if (accept && in_set_flags) begin
      flags_reg <= in_flags;
    end
  end

  assign in_ready     = (state_reg == IDLE);
  assign dmem_req     = (state_reg == ACCESS);
  assign dmem_we      = req_we_reg;
  assign dmem_addr    = req_addr_reg;
  assign dmem_wdata   = req_wdata_reg;
  assign wb_valid     = wb_valid_reg;
  assign wb_reg_write = wb_we_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_data      = wb_data_reg;
  assign mem_error    = mem_error_reg;
  assign status_flags = flags_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed plus randomized operations against a
// transaction-level model; one compare process checks outputs every cycle.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_fout;
  logic [DW-1:0] in_store_data;
  logic          in_mem_read;
  logic          in_mem_write;
  logic [4:0]    in_rd;
  logic          in_reg_write;
  logic [3:0]    in_flags;
  logic          in_set_flags;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid;
  logic          wb_reg_write;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic [3:0]    status_flags;
  logic          mem_error;

  mem_access_stage #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fout(in_fout), .in_store_data(in_store_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_flags(in_flags), .in_set_flags(in_set_flags),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .status_flags(status_flags), .mem_error(mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model expectations for the current cycle
  logic          exp_ready    = 1'b1;
  logic          exp_req      = 1'b0;
  logic          exp_we       = 1'b0;
  logic [DW-1:0] exp_addr     = '0;
  logic [DW-1:0] exp_wdata    = '0;
  logic          exp_wbv      = 1'b0;
  logic          exp_err      = 1'b0;
  logic          exp_wb_we    = 1'b0;
  logic [4:0]    exp_wb_rd    = 5'd0;
  logic [DW-1:0] exp_wb_data  = '0;
  logic          exp_chk_data = 1'b0;
  logic [3:0]    exp_flags    = 4'd0;
  logic          exp_rst_zero = 1'b1;

  // observation counters kept by the compare process
  int            req_total = 0;
  int            err_total = 0;
  int            wbv_total = 0;
  logic [DW-1:0] last_wb_data = '0;
  logic          last_wb_we   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("dmem_req", 32'(dmem_req), 32'(exp_req));
    chk("wb_valid", 32'(wb_valid), 32'(exp_wbv));
    chk("mem_error", 32'(mem_error), 32'(exp_err));
    chk("status_flags", 32'(status_flags), 32'(exp_flags));
    if (exp_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(exp_we));
      chk("dmem_addr", dmem_addr, exp_addr);
      chk("dmem_wdata", dmem_wdata, exp_wdata);
    end
    if (exp_wbv) begin
      chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_wb_we));
      if (exp_wb_we) chk("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
      if (exp_chk_data) chk("wb_data", wb_data, exp_wb_data);
    end
    if (exp_rst_zero) begin
      chk("rst_dmem_we", 32'(dmem_we), 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      chk("rst_wb_we", 32'(wb_reg_write), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
    end
    if (dmem_req) req_total++;
    if (mem_error) err_total++;
    if (wb_valid) begin
      wbv_total++;
      last_wb_data = wb_data;
      last_wb_we   = wb_reg_write;
      $display("wb: rd=%0d we=%0b data=%h err=%0b", wb_rd, wb_reg_write, wb_data, mem_error);
    end
  end

  // random inputs while the stage is busy; in_ready is low so nothing may be taken
  task automatic drive_junk();
    in_valid      = 1'($urandom_range(0, 1));
    in_fout       = $urandom;
    in_store_data = $urandom;
    in_mem_read   = 1'($urandom_range(0, 1));
    in_mem_write  = 1'($urandom_range(0, 1));
    in_rd         = 5'($urandom_range(0, 31));
    in_reg_write  = 1'($urandom_range(0, 1));
    in_flags      = 4'($urandom_range(0, 15));
    in_set_flags  = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_junk();
      in_valid   = 1'b0;
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  // One operation. ack_k: request cycle (1-based) in which memory acks;
  // beyond TO means no ack. abort_at: request cycle in which reset is pulled (0 = never).
  task automatic do_op(input logic [31:0] fout, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [3:0] fl, input logic sf,
                       input int ack_k, input logic [31:0] rdata, input int abort_at);
    logic is_mem;
    logic rejected;
    is_mem   = mr || mw;
    rejected = is_mem && ((mr && mw) || (fout[1:0] != 2'b00));
    exp_rst_zero  = 1'b0;
    in_valid      = 1'b1;
    in_fout       = fout;
    in_store_data = sdata;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_flags      = fl;
    in_set_flags  = sf;
    dmem_ack      = 1'($urandom_range(0, 1));
    dmem_rdata    = $urandom;
    $display("op: fout=%h sdata=%h rd=%0d rw=%0b mr=%0b mw=%0b ack_k=%0d abort=%0d",
             fout, sdata, rd, rw, mr, mw, ack_k, abort_at);
    @(posedge clk); #1;
    if (sf) exp_flags = fl;
    exp_ready = 1'b0;
    drive_junk();
    if (!is_mem || rejected) begin
      exp_wbv      = 1'b1;
      exp_err      = rejected;
      exp_wb_rd    = rd;
      exp_wb_we    = !is_mem && rw && (rd != 5'd0);
      exp_chk_data = !is_mem;
      exp_wb_data  = fout;
    end else begin
      exp_req   = 1'b1;
      exp_we    = mw;
      exp_addr  = fout;
      exp_wdata = sdata;
      for (int i = 1; i <= TO; i++) begin
        dmem_ack   = (i == ack_k);
        dmem_rdata = (i == ack_k) ? rdata : $urandom;
        if (i == abort_at) begin
          rst_n        = 1'b0;
          dmem_ack     = 1'b0;
          in_valid     = 1'b0;
          exp_req      = 1'b0;
          exp_ready    = 1'b1;
          exp_wbv      = 1'b0;
          exp_err      = 1'b0;
          exp_flags    = 4'd0;
          exp_rst_zero = 1'b1;
          @(posedge clk); #1;
          @(posedge clk); #1;
          rst_n = 1'b1;
          return;
        end
        @(posedge clk); #1;
        drive_junk();
        if (i == ack_k) begin
          exp_req      = 1'b0;
          exp_wbv      = 1'b1;
          exp_wb_rd    = rd;
          exp_wb_we    = mr && (rd != 5'd0);
          exp_chk_data = mr;
          exp_wb_data  = rdata;
          break;
        end
        if (i == TO) begin
          exp_req      = 1'b0;
          exp_wbv      = 1'b1;
          exp_err      = 1'b1;
          exp_wb_we    = 1'b0;
          exp_chk_data = 1'b0;
          break;
        end
      end
    end
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    exp_wbv      = 1'b0;
    exp_err      = 1'b0;
    exp_chk_data = 1'b0;
    exp_ready    = 1'b1;
    in_valid     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, e0, w0;
    logic [31:0] a;
    rst_n = 1'b0;
    drive_junk();
    in_valid   = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // ALU op
    r0 = req_total;
    do_op(32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1, 0, 32'h0, 0);
    chk("alu_data_lit", last_wb_data, 32'h10);
    chk("alu_we_lit", 32'(last_wb_we), 32'd1);
    chk("alu_flags_lit", 32'(status_flags), 32'h1);
    chk("alu_noreq_lit", 32'(req_total - r0), 32'd0);

    // load, ack in third request cycle
    r0 = req_total;
    do_op(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 3, 32'hDEAD_BEEF, 0);
    chk("load_req_cycles_lit", 32'(req_total - r0), 32'd3);
    chk("load_data_lit", last_wb_data, 32'hDEAD_BEEF);

    // store, immediate ack
    r0 = req_total;
    do_op(32'h200, 32'h1234_5678, 5'd3, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, 1, 32'h0, 0);
    chk("store_req_cycles_lit", 32'(req_total - r0), 32'd1);
    chk("store_we_lit", 32'(last_wb_we), 32'd0);

    // misaligned load, then read+write together
    r0 = req_total; e0 = err_total;
    do_op(32'h103, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1, 32'h0, 0);
    do_op(32'h104, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 4'b0, 1'b0, 1, 32'h0, 0);
    chk("illegal_noreq_lit", 32'(req_total - r0), 32'd0);
    chk("illegal_err_lit", 32'(err_total - e0), 32'd2);

    // timeout with no ack, then ack in the last allowed cycle
    r0 = req_total; e0 = err_total;
    do_op(32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, TO + 3, 32'h0, 0);
    chk("timeout_req_cycles_lit", 32'(req_total - r0), 32'd4);
    chk("timeout_err_lit", 32'(err_total - e0), 32'd1);
    r0 = req_total; e0 = err_total;
    do_op(32'h304, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, TO, 32'hCAFE_0001, 0);
    chk("lastack_req_cycles_lit", 32'(req_total - r0), 32'd4);
    chk("lastack_err_lit", 32'(err_total - e0), 32'd0);
    chk("lastack_data_lit", last_wb_data, 32'hCAFE_0001);

    // reset in the middle of an access
    w0 = wbv_total;
    do_op(32'h400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 4'b1010, 1'b1, TO + 3, 32'h0, 2);
    idle_cycles(3);
    chk("abort_no_wb_lit", 32'(wbv_total - w0), 32'd0);

    // load to r0 never writes
    do_op(32'h500, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 2, 32'h5555_AAAA, 0);
    chk("rd0_we_lit", 32'(last_wb_we), 32'd0);

    // randomized operations
    for (int n = 0; n < 250; n++) begin
      int kind;
      logic mr, mw;
      kind = int'($urandom_range(0, 9));
      mr = (kind >= 4 && kind <= 6) || kind == 9;
      mw = (kind >= 7 && kind <= 8) || (kind == 9 && $urandom_range(0, 1) == 1);
      a = $urandom;
      if ((mr || mw) && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      do_op(a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), mr, mw,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            int'($urandom_range(1, TO + 2)), $urandom,
            ($urandom_range(0, 24) == 0) ? 1 : 0);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the function-unit result, store operand and status flags from execute. Performs the data-memory load or store over a req/ack handshake, then presents a one-cycle writeback packet to the register file.
- Holds the 4-bit status register (overflow, carryout, negative, zero).
- Stalls execute via in_ready while a memory access is outstanding.

Parameters:
- DATA_W, 32, width of data, address and result buses.
- TIMEOUT, 255, maximum cycles to wait for dmem_ack before aborting. Range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  execute presents a valid operation.
- in_ready  output  1  stage can accept an operation this cycle.
- in_fout  input  DATA_W  function-unit result; used as the memory address for loads and stores.
- in_store_data  input  DATA_W  store operand (busB).
- in_mem_read  input  1  operation is a load.
- in_mem_write  input  1  operation is a store.
- in_rd  input  5  destination register index.
- in_reg_write  input  1  operation writes a register.
- in_flags  input  4  {overflow, carryout, negative, zero} from execute.
- in_set_flags  input  1  update the status register with in_flags.
- dmem_req  output  1  memory request.
- dmem_we  output  1  1 = write, 0 = read.
- dmem_addr  output  DATA_W  word address (byte address, 4-aligned).
- dmem_wdata  output  DATA_W  store data.
- dmem_ack  input  1  memory completes the request this cycle.
- dmem_rdata  input  DATA_W  load data, valid while dmem_ack = 1.
- wb_valid  output  1  one-cycle writeback pulse.
- wb_reg_write  output  1  write enable for the register file.
- wb_rd  output  5  destination register.
- wb_data  output  DATA_W  writeback value.
- status_flags  output  4  registered {V, C, N, Z}.
- mem_error  output  1  one-cycle pulse on misalignment, illegal op or timeout.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0, except in_ready = 1.
  - Timeout counter is 0.
  - Reset mid-access abandons the access immediately: dmem_req drops and no writeback is issued.
- Acceptance:
  - An operation is accepted on a rising edge where in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - On accept with in_set_flags = 1, status_flags <= in_flags on that edge, independent of what the memory access later does.
- FSM states: IDLE, ACCESS, WB.
  - IDLE, accepting a non-memory operation: go to WB. wb_data = in_fout; wb_reg_write = in_reg_write && (in_rd != 0).
  - IDLE, accepting a memory operation:
    - Error case: in_mem_read && in_mem_write, or in_fout[1:0] != 0. Go to WB with wb_reg_write = 0 and pulse mem_error in the WB cycle. No memory request is issued.
    - Otherwise: go to ACCESS. dmem_req = 1, dmem_we = in_mem_write, dmem_addr = in_fout, dmem_wdata = in_store_data, all registered and held stable until ack.
  - ACCESS:
    - The counter increments each cycle.
    - On dmem_ack = 1: capture dmem_rdata (load) and go to WB. For a load, wb_reg_write = in_rd != 0; for a store, wb_reg_write = 0. dmem_req deasserts on the next cycle.
    - If the counter reaches TIMEOUT without ack: drop dmem_req, go to WB with wb_reg_write = 0, pulse mem_error.
    - An ack on the same cycle the timeout is reached counts as success.
  - WB: wb_valid = 1 for exactly one cycle; next state is IDLE.
- Latency:
  - Non-memory: accept at edge N, wb_valid high in cycle N+1, in_ready high again in cycle N+2.
  - Memory: dmem_req high from cycle N+1; if ack is sampled at edge M, wb_valid is high in cycle M+1.
- Handshake rules:
  - dmem_ack is ignored when dmem_req = 0.
  - dmem_req never drops before ack or timeout.
- Outputs between pulses:
  - wb_rd, wb_data and wb_reg_write hold their last values when wb_valid = 0.
  - wb_reg_write is only meaningful while wb_valid = 1.

Test Plan:
- Reset then ALU op: in_fout = 0x0000_0010, rd = 5, reg_write = 1, flags = 4'b0001, set_flags = 1 -> wb_valid in the next cycle with wb_data = 0x10, wb_rd = 5, wb_reg_write = 1; status_flags = 0001; no dmem_req.
- Load from 0x100 with memory acking 3 cycles later with rdata 0xDEADBEEF -> dmem_req high for 3 cycles with we = 0 and addr = 0x100; in_ready = 0 throughout; then wb_valid with wb_data = 0xDEADBEEF.
- Store of 0x1234_5678 to 0x200 with an immediate ack -> dmem_we = 1, dmem_wdata = 0x12345678; wb_valid with wb_reg_write = 0.
- Misaligned load at 0x103, then read+write both set -> no dmem_req; mem_error pulse with wb_valid and wb_reg_write = 0 for each.
- TIMEOUT = 4 with no ack -> dmem_req high for 4 cycles then low; mem_error and wb_valid pulse; in_ready returns. Ack on the 4th cycle instead -> normal writeback, no error.
- rst_n pulled low during ACCESS -> dmem_req = 0 immediately, no wb_valid, in_ready = 1; rd = 0 load -> wb_reg_write = 0.
